// File: rtl/flappy_game_sequencer.sv
// Game sequencer: canvas clear, per-layer initial draw and erase/redraw, crash/fall, lives and game over.
// Optional FLAPPY_PAUSE_EN adds a pause input and a PAUSED state entered from WAIT_FRAME.
module flappy_game_sequencer #(
   parameter int N_LAYERS  = 3,
   parameter int LAYER_W   = 2,
   parameter int FRAME_DIV = 1,
   parameter int LIVES     = 3,
   parameter int LIVES_W   = 2
) (
   input  logic               clk,
   input  logic               resetLow,
   input  logic               flap,
   input  logic               frameactive,
   input  logic               outputFinish,
   input  logic               clrCanvasFinish,
   input  logic               collisionOccurred,
   input  logic               birdGrounded,
`ifdef FLAPPY_PAUSE_EN
   input  logic               pause,
`endif
   output logic               plotEnable,
   output logic               oldOrCurrent,
   output logic               loadEnableDataPath,
   output logic               dropEnable,
   output logic               clrCanvasScreenEnable,
   output logic               clrCanvasXYOrRetainXYToVGA,
   output logic [LAYER_W-1:0] layerSel,
   output logic               freezeX,
   output logic               respawn,
   output logic [LIVES_W-1:0] livesLeft,
   output logic               gameOver
);

   localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);
   localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(FRAME_DIV - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

   typedef enum logic [3:0] {
      CLR_SETUP   = 4'd0,
      CLR         = 4'd1,
      INIT_SETUP  = 4'd2,
      INIT_DRAW   = 4'd3,
      WAIT_FLAP   = 4'd4,
      WAIT_FRAME  = 4'd5,
      ERASE_SETUP = 4'd6,
      ERASE       = 4'd7,
      DRAW_SETUP  = 4'd8,
      DRAW        = 4'd9,
      CHECK       = 4'd10,
      CONT        = 4'd11,
      COLLIDE     = 4'd12,
      LIFE_LOST   = 4'd13,
`ifdef FLAPPY_PAUSE_EN
      PAUSED      = 4'd15,
`endif
      GAME_OVER   = 4'd14
   } state_t;

   state_t state_r, next_s;
   logic [LAYER_W-1:0] layer_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               crashed_r;
   logic [LIVES_W-1:0] lives_r;
   logic               pause_s;
   logic               layer_last_s, cnt_last_s, tick_s;
   logic plot_s, oc_s, load_s, drop_s, clr_s, xy_s, respawn_s, over_s;

`ifdef FLAPPY_PAUSE_EN
   assign pause_s = pause;
`else
   assign pause_s = 1'b0;
`endif

   assign layer_last_s = (layer_r == LAST_LAYER);
   assign cnt_last_s   = (cnt_r == LAST_CNT);
   // A pause request wins over a simultaneous tick, so that tick is not counted.
   assign tick_s       = (state_r == WAIT_FRAME) && frameactive && !pause_s;

   // State register.
   always_ff @(posedge clk or negedge resetLow) begin
      if (!resetLow) state_r <= CLR_SETUP;
      else           state_r <= next_s;
   end

   // Next-state decode.
   always_comb begin
      next_s = state_r;
      case (state_r)
         CLR_SETUP:   next_s = CLR;
         CLR:         if (clrCanvasFinish) next_s = INIT_SETUP; else next_s = CLR;
         INIT_SETUP:  next_s = INIT_DRAW;
         INIT_DRAW:   if (outputFinish) next_s = layer_last_s ? WAIT_FLAP : INIT_SETUP;
                      else next_s = INIT_DRAW;
         WAIT_FLAP:   if (!flap) next_s = WAIT_FRAME; else next_s = WAIT_FLAP;
         WAIT_FRAME: begin
`ifdef FLAPPY_PAUSE_EN
            if (pause_s) next_s = PAUSED;
            else
`endif
            if (tick_s && cnt_last_s) next_s = ERASE_SETUP;
            else next_s = WAIT_FRAME;
         end
         ERASE_SETUP: next_s = ERASE;
         ERASE:       if (outputFinish) next_s = layer_last_s ? DRAW_SETUP : ERASE_SETUP;
                      else next_s = ERASE;
         DRAW_SETUP:  next_s = DRAW;
         DRAW:        if (outputFinish) next_s = layer_last_s ? CHECK : DRAW_SETUP;
                      else next_s = DRAW;
         CHECK: begin
            if (crashed_r && birdGrounded)            next_s = LIFE_LOST;
            else if (crashed_r || collisionOccurred)  next_s = COLLIDE;
            else                                      next_s = CONT;
         end
         CONT, COLLIDE: next_s = WAIT_FRAME;
         LIFE_LOST:   if (lives_r <= LIVES_W'(1)) next_s = GAME_OVER; else next_s = CLR_SETUP;
         GAME_OVER:   if (!flap) next_s = CLR_SETUP; else next_s = GAME_OVER;
`ifdef FLAPPY_PAUSE_EN
         PAUSED:      if (!pause_s) next_s = WAIT_FRAME; else next_s = PAUSED;
`endif
         default:     next_s = CLR_SETUP;
      endcase
   end

   // Output decode of the upcoming state, so the registered outputs track state_r exactly.
   always_comb begin
      plot_s = 1'b0; oc_s = 1'b0; load_s = 1'b0; drop_s = 1'b0;
      clr_s = 1'b0; xy_s = 1'b1; respawn_s = 1'b0; over_s = 1'b0;
      case (next_s)
         CLR_SETUP:                begin clr_s = 1'b1; xy_s = 1'b0; respawn_s = 1'b1; end
         CLR:                      begin plot_s = 1'b1; xy_s = 1'b0; end
         INIT_SETUP, DRAW_SETUP:   begin load_s = 1'b1; oc_s = 1'b1; end
         ERASE_SETUP:              load_s = 1'b1;
         INIT_DRAW, ERASE, DRAW:   plot_s = 1'b1;
         CONT, COLLIDE:            drop_s = 1'b1;
         GAME_OVER:                over_s = 1'b1;
         default:                  plot_s = 1'b0;
      endcase
   end

   // Output registers, reset to the CLR_SETUP decode.
   always_ff @(posedge clk or negedge resetLow) begin
      if (!resetLow) begin
         plotEnable <= 1'b0; oldOrCurrent <= 1'b0; loadEnableDataPath <= 1'b0; dropEnable <= 1'b0;
         clrCanvasScreenEnable <= 1'b1; clrCanvasXYOrRetainXYToVGA <= 1'b0;
         respawn <= 1'b1; gameOver <= 1'b0;
      end else begin
         plotEnable <= plot_s; oldOrCurrent <= oc_s; loadEnableDataPath <= load_s; dropEnable <= drop_s;
         clrCanvasScreenEnable <= clr_s; clrCanvasXYOrRetainXYToVGA <= xy_s;
         respawn <= respawn_s; gameOver <= over_s;
      end
   end

   // Layer index, frame divider, crash flag and lives bookkeeping.
   always_ff @(posedge clk or negedge resetLow) begin
      if (!resetLow) begin
         layer_r   <= '0;
         cnt_r     <= '0;
         crashed_r <= 1'b0;
         lives_r   <= LIVES_INIT;
      end else begin
         case (state_r)
            CLR_SETUP: begin
               crashed_r <= 1'b0;
               layer_r   <= '0;
            end
            INIT_DRAW, ERASE, DRAW:
               if (outputFinish) layer_r <= layer_last_s ? '0 : layer_r + LAYER_W'(1);
            WAIT_FRAME:
               if (tick_s) cnt_r <= cnt_last_s ? '0 : cnt_r + CNT_W'(1);
            COLLIDE:   crashed_r <= 1'b1;
            LIFE_LOST: if (lives_r != '0) lives_r <= lives_r - LIVES_W'(1);
            GAME_OVER: if (!flap) lives_r <= LIVES_INIT;
            default:   layer_r <= layer_r;
         endcase
      end
   end

   assign layerSel  = layer_r;
   assign freezeX   = crashed_r;
   assign livesLeft = lives_r;

endmodule

// File: tb/tb_flappy_game_sequencer.sv
// Scoreboard bench for flappy_game_sequencer: expected load/drop/respawn events are queued with the
// stimulus and popped by a monitor; the FLAPPY_PAUSE_EN section runs only when that macro is defined.
module tb_flappy_game_sequencer;

   logic clk = 1'b0;
   logic resetLow, flap, frameactive, outputFinish, clrCanvasFinish, collisionOccurred, birdGrounded;
`ifdef FLAPPY_PAUSE_EN
   logic pause;
`endif
   logic plotEnable, oldOrCurrent, loadEnableDataPath, dropEnable, clrCanvasScreenEnable;
   logic clrCanvasXYOrRetainXYToVGA, freezeX, respawn, gameOver;
   logic [1:0] layerSel, livesLeft;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];
   bit mon_en = 1'b0;
   bit hold   = 1'b0;
   bit last_oc = 1'b0;

   flappy_game_sequencer #(.N_LAYERS(3), .LAYER_W(2), .FRAME_DIV(3), .LIVES(3), .LIVES_W(2)) dut (
      .clk(clk), .resetLow(resetLow), .flap(flap), .frameactive(frameactive),
      .outputFinish(outputFinish), .clrCanvasFinish(clrCanvasFinish),
      .collisionOccurred(collisionOccurred), .birdGrounded(birdGrounded),
`ifdef FLAPPY_PAUSE_EN
      .pause(pause),
`endif
      .plotEnable(plotEnable), .oldOrCurrent(oldOrCurrent), .loadEnableDataPath(loadEnableDataPath),
      .dropEnable(dropEnable), .clrCanvasScreenEnable(clrCanvasScreenEnable),
      .clrCanvasXYOrRetainXYToVGA(clrCanvasXYOrRetainXYToVGA), .layerSel(layerSel),
      .freezeX(freezeX), .respawn(respawn), .livesLeft(livesLeft), .gameOver(gameOver)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: every load/drop/respawn pulse is one event compared against the queue head.
   always @(negedge clk) begin
      logic [7:0] code;
      if (mon_en) begin
         if (loadEnableDataPath)
            code = {4'h1, 1'b0, oldOrCurrent, layerSel};
         else if (dropEnable)
            code = {7'b0010000, freezeX};
         else if (respawn)
            code = {4'h3, 2'b00, livesLeft};
         else
            code = 8'h00;
         if (code != 8'h00) begin
            if (exp_q.size() == 0) check_eq("unexpected_event", {24'h0, code}, 32'h0);
            else check_eq("event", {24'h0, code}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // Plot/clear handshake responder; can stall the DRAW of layer 2.
   initial begin
      forever begin
         @(negedge clk);
         if (loadEnableDataPath) last_oc = oldOrCurrent;
         clrCanvasFinish = plotEnable && !clrCanvasXYOrRetainXYToVGA;
         outputFinish    = plotEnable && clrCanvasXYOrRetainXYToVGA &&
                           !(hold && last_oc && layerSel == 2'd2);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_init();
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h14 + 8'(i));
   endtask

   task automatic push_frame();
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h14 + 8'(i));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain", exp_q.size(), 0);
      exp_q.delete();
      repeat (6) @(negedge clk);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); frameactive = 1'b1;
         @(negedge clk); frameactive = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic press_flap();
      @(negedge clk); flap = 1'b0;
      @(negedge clk); flap = 1'b1;
   endtask

   task automatic step(input int n);
      tick(n);
      wait_drain();
   endtask

   // One life: collide on one step, fall to the ground on the next.
   task automatic lose_life(input bit simul, input int lives_after);
      press_flap();
      push_frame(); exp_q.push_back(8'h20);
      collisionOccurred = 1'b1; birdGrounded = simul;
      step(3);
      collisionOccurred = 1'b0;
      push_frame();
      if (lives_after > 0) begin
         exp_q.push_back(8'h30 + 8'(lives_after));
         push_init();
      end
      birdGrounded = 1'b1;
      step(3);
      birdGrounded = 1'b0;
      check_eq("lives_after_loss", livesLeft, lives_after);
   endtask

   initial begin
      resetLow = 1'b0; flap = 1'b1; frameactive = 1'b0;
      collisionOccurred = 1'b0; birdGrounded = 1'b0;
`ifdef FLAPPY_PAUSE_EN
      pause = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_eq("reset_outputs",
               {clrCanvasScreenEnable, clrCanvasXYOrRetainXYToVGA, respawn, plotEnable,
                loadEnableDataPath, dropEnable, gameOver, freezeX}, 8'b10100000);
      check_eq("reset_layer", layerSel, 0);
      check_eq("reset_lives", livesLeft, 3);

      // Clear and initial draw of three layers.
      push_init();
      resetLow = 1'b1;
      @(posedge clk); mon_en = 1'b1;
      wait_drain();
      check_eq("wait_flap_layer", layerSel, 0);
      check_eq("wait_flap_idle", {plotEnable, loadEnableDataPath, dropEnable}, 3'b000);

      // Ticks before the flap are ignored; then two divided steps from six ticks.
      tick(2);
      press_flap();
      push_frame(); exp_q.push_back(8'h20);
      step(3);
      push_frame(); exp_q.push_back(8'h20);
      step(3);
      tick(2);
      repeat (30) @(negedge clk);
      check_eq("no_step_after_two", exp_q.size(), 0);
      push_frame(); exp_q.push_back(8'h20);
      step(1);

      // Collision, crashed fall and ground contact.
      push_frame(); exp_q.push_back(8'h20);
      collisionOccurred = 1'b1;
      step(3);
      collisionOccurred = 1'b0;
      check_eq("freeze_after_collide", freezeX, 1);
      push_frame(); exp_q.push_back(8'h21);
      step(3);
      check_eq("still_frozen", freezeX, 1);
      push_frame(); exp_q.push_back(8'h32); push_init();
      birdGrounded = 1'b1;
      step(3);
      birdGrounded = 1'b0;
      check_eq("freeze_cleared", freezeX, 0);
      check_eq("lives_two", livesLeft, 2);

      // Reset in the middle of DRAW on layer 2.
      press_flap();
      hold = 1'b1;
      push_frame();
      tick(3);
      wait_drain();
      check_eq("stalled_draw", {plotEnable, layerSel}, 3'b110);
      mon_en = 1'b0;
      resetLow = 1'b0;
      #1;
      check_eq("midplot_reset_outputs", {clrCanvasScreenEnable, respawn, plotEnable}, 3'b110);
      check_eq("midplot_reset_layer", layerSel, 0);
      check_eq("midplot_reset_lives", livesLeft, 3);
      @(negedge clk); resetLow = 1'b1; hold = 1'b0;
      push_init();
      @(posedge clk); mon_en = 1'b1;
      wait_drain();

      // Lose all lives (first one with collision and ground together), then restart.
      lose_life(1'b1, 2);
      lose_life(1'b0, 1);
      lose_life(1'b0, 0);
      check_eq("game_over", gameOver, 1);
      exp_q.push_back(8'h33); push_init();
      press_flap();
      wait_drain();
      check_eq("restart_lives", livesLeft, 3);
      check_eq("restart_no_game_over", gameOver, 0);

`ifdef FLAPPY_PAUSE_EN
      press_flap();
      tick(1);
      @(negedge clk); pause = 1'b1;
      repeat (2) @(negedge clk);
      tick(5);
      repeat (30) @(negedge clk);
      check_eq("paused_no_erase", exp_q.size(), 0);
      pause = 1'b0;
      repeat (2) @(negedge clk);
      tick(1);
      repeat (30) @(negedge clk);
      check_eq("resume_one_tick", exp_q.size(), 0);
      push_frame(); exp_q.push_back(8'h20);
      step(1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
